// File: rtl/cc_alu_pkg.sv
// cc_alu_pkg: ALU select encodings, sequencer state type and width defaults
package cc_alu_pkg;
    localparam int DATAWIDTH_BUS_DEF           = 32;
    localparam int DATAWIDTH_ALU_SELECTION_DEF = 4;
    localparam int COUNT_WIDTH_DEF             = 5;
    localparam logic [3:0] SEL_ORCC   = 4'b0011;
    localparam logic [3:0] SEL_PASS_A = 4'b0100;
    localparam logic [3:0] SEL_ADD    = 4'b1000;
    typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;
endpackage

// File: rtl/cc_alu_sequencer_if.sv
// cc_alu_sequencer_if: command, ALU and response signals of the sequencer
//   slave: the sequencer; master: command source, ALU and response sink
interface cc_alu_sequencer_if #(
    parameter int DATAWIDTH_BUS           = cc_alu_pkg::DATAWIDTH_BUS_DEF,
    parameter int DATAWIDTH_ALU_SELECTION = cc_alu_pkg::DATAWIDTH_ALU_SELECTION_DEF,
    parameter int COUNT_WIDTH             = cc_alu_pkg::COUNT_WIDTH_DEF
);
    logic                               Cmd_Valid_InHigh;
    logic                               Cmd_Ready_OutHigh;
    logic [4:0]                         Cmd_Op_In;
    logic [DATAWIDTH_BUS-1:0]           Cmd_A_In;
    logic [DATAWIDTH_BUS-1:0]           Cmd_B_In;
    logic [COUNT_WIDTH-1:0]             Cmd_Count_In;
    logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_Selection_Out;
    logic [DATAWIDTH_BUS-1:0]           ALU_DataBUSA_Out;
    logic [DATAWIDTH_BUS-1:0]           ALU_DataBUSB_Out;
    logic [DATAWIDTH_BUS-1:0]           ALU_DataBUS_In;
    logic [3:0]                         ALU_Flags_In;
    logic                               Rsp_Valid_OutHigh;
    logic                               Rsp_Ready_InHigh;
    logic [DATAWIDTH_BUS-1:0]           Rsp_Data_Out;
    logic [3:0]                         PSR_Out;
    modport master (
        output Cmd_Valid_InHigh, Cmd_Op_In, Cmd_A_In, Cmd_B_In, Cmd_Count_In,
               ALU_DataBUS_In, ALU_Flags_In, Rsp_Ready_InHigh,
        input  Cmd_Ready_OutHigh, ALU_Selection_Out, ALU_DataBUSA_Out, ALU_DataBUSB_Out,
               Rsp_Valid_OutHigh, Rsp_Data_Out, PSR_Out
    );
    modport slave (
        input  Cmd_Valid_InHigh, Cmd_Op_In, Cmd_A_In, Cmd_B_In, Cmd_Count_In,
               ALU_DataBUS_In, ALU_Flags_In, Rsp_Ready_InHigh,
        output Cmd_Ready_OutHigh, ALU_Selection_Out, ALU_DataBUSA_Out, ALU_DataBUSB_Out,
               Rsp_Valid_OutHigh, Rsp_Data_Out, PSR_Out
    );
endinterface

// File: rtl/cc_psr_reg.sv
// cc_psr_reg: 4-bit {N,Z,V,C} condition-code register with load enable
//   clk, rst_n (async, active-low), load_en, flags_d -> psr_q
module cc_psr_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_en,
    input  logic [3:0] flags_d,
    output logic [3:0] psr_q
);
    logic [3:0] psr_d;
    always_comb psr_d = load_en ? flags_d : psr_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) psr_q <= '0;
        else        psr_q <= psr_d;
endmodule

// File: rtl/cc_alu_sequencer.sv
// cc_alu_sequencer: sequences native ALU ops and repeated-add (REPADD) over an external ALU
//   CC_ALU_SEQUENCER_CLOCK_50, CC_ALU_SEQUENCER_RESET_InLow (async, active-low),
//   bus (slave): command in, ALU select/operands out, ALU result/flags in, response out, PSR_Out
//   CC_ALU_SEQUENCER_REPADD_EN enables REPADD; otherwise op bit4 is a single pass-A op
module cc_alu_sequencer
    import cc_alu_pkg::*;
#(
    parameter int DATAWIDTH_BUS           = DATAWIDTH_BUS_DEF,
    parameter int DATAWIDTH_ALU_SELECTION = DATAWIDTH_ALU_SELECTION_DEF,
    parameter int COUNT_WIDTH             = COUNT_WIDTH_DEF
) (
    input logic               CC_ALU_SEQUENCER_CLOCK_50,
    input logic               CC_ALU_SEQUENCER_RESET_InLow,
    cc_alu_sequencer_if.slave bus
);
`ifdef CC_ALU_SEQUENCER_REPADD_EN
    localparam bit REPADD_ON = 1'b1;
`else
    localparam bit REPADD_ON = 1'b0;
`endif
    state_t                   state_q, state_d;
    logic [4:0]               op_q, op_d;
    logic [DATAWIDTH_BUS-1:0] acc_q, acc_d, b_q, b_d, bus_a, bus_b;
    logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [3:0]               flags_q, flags_d, sel, psr;
    logic                     ready_q, accept, psr_load;

    assign accept = bus.Cmd_Valid_InHigh && ready_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        flags_d  = flags_q;
        sel      = SEL_PASS_A;
        bus_a    = '0;
        bus_b    = '0;
        psr_load = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                op_d    = bus.Cmd_Op_In;
                acc_d   = bus.Cmd_A_In;
                b_d     = bus.Cmd_B_In;
                cnt_d   = bus.Cmd_Count_In;
                flags_d = '0;
                state_d = (REPADD_ON && bus.Cmd_Op_In[4] && bus.Cmd_Count_In != '0) ? ITER : EXEC;
            end
            EXEC: begin
                sel     = op_q[4] ? SEL_PASS_A : op_q[3:0];
                bus_a   = acc_q;
                bus_b   = b_q;
                acc_d   = bus.ALU_DataBUS_In;
                flags_d = bus.ALU_Flags_In;
                state_d = DONE;
            end
            ITER: begin
                sel     = SEL_ADD;
                bus_a   = acc_q;
                bus_b   = b_q;
                acc_d   = bus.ALU_DataBUS_In;
                cnt_d   = cnt_q - COUNT_WIDTH'(1);
                // N,Z track the latest pass; V,C accumulate over every pass
                flags_d = {bus.ALU_Flags_In[3:2], flags_q[1:0] | bus.ALU_Flags_In[1:0]};
                state_d = (cnt_q == COUNT_WIDTH'(1)) ? DONE : ITER;
            end
            DONE: if (bus.Rsp_Ready_InHigh) begin
                psr_load = op_q[4] ? REPADD_ON : (op_q[3:0] <= SEL_ORCC);
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge CC_ALU_SEQUENCER_CLOCK_50 or negedge CC_ALU_SEQUENCER_RESET_InLow) begin
        if (!CC_ALU_SEQUENCER_RESET_InLow) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            // registered so ready stays low throughout reset and rises on the first edge after
            ready_q <= (state_d == IDLE);
        end
    end

    cc_psr_reg u_psr (
        .clk     (CC_ALU_SEQUENCER_CLOCK_50),
        .rst_n   (CC_ALU_SEQUENCER_RESET_InLow),
        .load_en (psr_load),
        .flags_d (flags_q),
        .psr_q   (psr)
    );

    assign bus.Cmd_Ready_OutHigh = ready_q;
    assign bus.ALU_Selection_Out = DATAWIDTH_ALU_SELECTION'(sel);
    assign bus.ALU_DataBUSA_Out  = bus_a;
    assign bus.ALU_DataBUSB_Out  = bus_b;
    assign bus.Rsp_Valid_OutHigh = (state_q == DONE);
    assign bus.Rsp_Data_Out      = (state_q == DONE) ? acc_q : '0;
    assign bus.PSR_Out           = psr;
endmodule

// File: tb/tb_cc_alu_sequencer.sv
// tb_cc_alu_sequencer: directed bench with ALU responder and cycle-level reference model
module tb_cc_alu_sequencer;
`ifdef CC_ALU_SEQUENCER_REPADD_EN
    localparam bit REPADD_ON = 1'b1;
`else
    localparam bit REPADD_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cc_alu_sequencer_if bus ();

    cc_alu_sequencer dut (
        .CC_ALU_SEQUENCER_CLOCK_50    (clk),
        .CC_ALU_SEQUENCER_RESET_InLow (rst_n),
        .bus                          (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        v, c;
        v = 1'b0;
        c = 1'b0;
        w = {1'b0, a} + {1'b0, b};
        case (s)
            4'b0000, 4'b1000: begin r = w[31:0]; c = w[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0001, 4'b1001: begin r = a - b; c = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'b0010, 4'b0101: r = a & b;
            4'b0011, 4'b0110: r = a | b;
            4'b0100:          r = a;
            4'b0111:          r = a ^ b;
            default:          r = '0;
        endcase
        return {r[31], (r == 32'd0), v, c, r};
    endfunction

    always_comb {bus.ALU_Flags_In, bus.ALU_DataBUS_In} =
        alu_f(bus.ALU_Selection_Out, bus.ALU_DataBUSA_Out, bus.ALU_DataBUSB_Out);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_cmd(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] n, output logic [31:0] d, output logic [3:0] f,
                                      output bit upd, output int lat);
        logic [35:0] p;
        logic [31:0] r;
        if (op[4] && REPADD_ON && n != 0) begin
            d = a + 32'(n) * b;
            f = '0;
            r = a;
            for (int i = 0; i < int'(n); i++) begin
                p = alu_f(4'b1000, r, b);
                r = p[31:0];
                f = {p[35:34], f[1:0] | p[33:32]};
            end
            upd = 1'b1;
            lat = int'(n) + 1;
        end else begin
            p   = alu_f(op[4] ? 4'b0100 : op[3:0], a, b);
            d   = p[31:0];
            f   = p[35:32];
            upd = op[4] ? REPADD_ON : (op[3:2] == 2'b00);
            lat = 2;
        end
    endfunction

    bit          pending = 1'b0, rdy_ok = 1'b0, m_upd = 1'b0;
    int          cyc = 0, valid_from = 0, acc_cyc = 0, m_lat = 0;
    logic [4:0]  m_op = '0, m_n = '0;
    logic [31:0] m_a = '0, m_b = '0, m_d = '0;
    logic [3:0]  m_f = '0, exp_psr = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending = 1'b0;
            rdy_ok  = 1'b0;
            exp_psr = '0;
        end else begin
            if (pending && cyc >= valid_from && bus.Rsp_Ready_InHigh) begin
                pending = 1'b0;
                if (m_upd) exp_psr = m_f;
            end else if (!pending && rdy_ok && bus.Cmd_Valid_InHigh) begin
                m_op = bus.Cmd_Op_In;
                m_a  = bus.Cmd_A_In;
                m_b  = bus.Cmd_B_In;
                m_n  = bus.Cmd_Count_In;
                model_cmd(m_op, m_a, m_b, m_n, m_d, m_f, m_upd, m_lat);
                pending    = 1'b1;
                valid_from = cyc + m_lat;
                acc_cyc    = cyc + 1;
            end
            cyc++;
            rdy_ok = !pending;
        end
    end

    always @(negedge clk) if (chk_en) begin
        bit          vld, busy, rep;
        logic [3:0]  e_sel;
        logic [31:0] e_a;
        vld   = pending && cyc >= valid_from;
        busy  = pending && cyc < valid_from;
        rep   = m_op[4] && REPADD_ON && m_n != 0;
        e_sel = rep ? 4'b1000 : (m_op[4] ? 4'b0100 : m_op[3:0]);
        e_a   = rep ? m_a + 32'(cyc - acc_cyc) * m_b : m_a;
        chk("cmd_ready", bus.Cmd_Ready_OutHigh, rdy_ok);
        chk("rsp_valid", bus.Rsp_Valid_OutHigh, vld);
        if (vld) chk("rsp_data", bus.Rsp_Data_Out, m_d);
        if (!rst_n) chk("rsp_data_rst", bus.Rsp_Data_Out, 0);
        chk("psr", bus.PSR_Out, exp_psr);
        chk("alu_sel", bus.ALU_Selection_Out, busy ? e_sel : 4'b0100);
        chk("alu_a", bus.ALU_DataBUSA_Out, busy ? e_a : 32'd0);
        chk("alu_b", bus.ALU_DataBUSB_Out, busy ? m_b : 32'd0);
    end

    task automatic wait_ready();
        int k = 0;
        while (!bus.Cmd_Ready_OutHigh && k < 50) begin @(posedge clk); #1; k++; end
        chk("ready_wait", bus.Cmd_Ready_OutHigh, 1);
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] n);
        wait_ready();
        bus.Cmd_Valid_InHigh = 1'b1;
        bus.Cmd_Op_In        = op;
        bus.Cmd_A_In         = a;
        bus.Cmd_B_In         = b;
        bus.Cmd_Count_In     = n;
        @(posedge clk); #1;
        bus.Cmd_Valid_InHigh = 1'b0;
    endtask

    task automatic run_cmd(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] n, input int hold, input int e_lat,
                           input logic [31:0] e_d, input logic [3:0] e_p);
        int k;
        issue(op, a, b, n);
        k = 1;
        while (!bus.Rsp_Valid_OutHigh && k < 100) begin @(posedge clk); #1; k++; end
        chk({nm, "_latency"}, k, e_lat);
        chk({nm, "_data"}, bus.Rsp_Data_Out, e_d);
        repeat (hold) begin
            bus.Cmd_Valid_InHigh = 1'b1;
            bus.Cmd_Op_In        = 5'h01;
            bus.Cmd_A_In         = 32'd0;
            bus.Cmd_B_In         = 32'd5;
            @(posedge clk); #1;
            chk({nm, "_held_ready"}, bus.Cmd_Ready_OutHigh, 0);
        end
        bus.Cmd_Valid_InHigh = 1'b0;
        if (hold > 0) chk({nm, "_held_data"}, bus.Rsp_Data_Out, e_d);
        bus.Rsp_Ready_InHigh = 1'b1;
        @(posedge clk); #1;
        bus.Rsp_Ready_InHigh = 1'b0;
        chk({nm, "_psr"}, bus.PSR_Out, e_p);
        chk({nm, "_ready_next"}, bus.Cmd_Ready_OutHigh, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Cmd_Valid_InHigh = 1'b0;
        bus.Cmd_Op_In        = '0;
        bus.Cmd_A_In         = '0;
        bus.Cmd_B_In         = '0;
        bus.Cmd_Count_In     = '0;
        bus.Rsp_Ready_InHigh = 1'b0;
        #3 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.Cmd_Ready_OutHigh, 0);
        chk("rst_psr", bus.PSR_Out, 0);
        rst_n = 1'b1;
        chk("release_ready_low", bus.Cmd_Ready_OutHigh, 0);
        @(posedge clk); #1;
        chk("release_ready_high", bus.Cmd_Ready_OutHigh, 1);

        run_cmd("addcc", 5'h00, 32'h7FFFFFFF, 32'd1, 5'd0, 0, 2, 32'h80000000, 4'b1010);
        run_cmd("and", 5'h05, 32'hFF, 32'h0F, 5'd0, 0, 2, 32'h0F, 4'b1010);
        run_cmd("repadd_n0", 5'h10, 32'h1234, 32'd7, 5'd0, 0, 2, 32'h1234, REPADD_ON ? 4'b0000 : 4'b1010);
        run_cmd("repadd_5_3_4", 5'h10, 32'd5, 32'd3, 5'd4, 0, REPADD_ON ? 5 : 2,
                REPADD_ON ? 32'd17 : 32'd5, REPADD_ON ? 4'b0000 : 4'b1010);
        run_cmd("repadd_wrap", 5'h10, 32'hFFFFFFFF, 32'd1, 5'd2, 0, REPADD_ON ? 3 : 2,
                REPADD_ON ? 32'd1 : 32'hFFFFFFFF, REPADD_ON ? 4'b0001 : 4'b1010);
        run_cmd("subcc_bp", 5'h01, 32'd0, 32'd1, 5'd0, 3, 2, 32'hFFFFFFFF, 4'b1001);

        issue(5'h10, 32'd0, 32'd1, 5'd20);
        repeat (7) @(posedge clk);
        #1;
        chk("pre_reset_psr", bus.PSR_Out, 4'b1001);
        rst_n = 1'b0;
        #1;
        chk("iter_rst_valid", bus.Rsp_Valid_OutHigh, 0);
        chk("iter_rst_psr", bus.PSR_Out, 0);
        chk("iter_rst_ready", bus.Cmd_Ready_OutHigh, 0);
        chk("iter_rst_sel", bus.ALU_Selection_Out, 4'b0100);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("iter_rst_ready_back", bus.Cmd_Ready_OutHigh, 1);

        run_cmd("orcc_zero", 5'h03, 32'd0, 32'd0, 5'd0, 0, 2, 32'd0, 4'b0100);
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
